// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core with load-use hazard
// detection, bubble insertion and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_data1,
  input  logic [DATA_W-1:0] id_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemToReg,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic [2:0]        id_ALUOp,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemToReg,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic [2:0]        ex_ALUOp,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  // {RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc}
  logic [5:0]        ctl_q, ctl_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              hz;

  always_comb begin
    hz = valid_q & ctl_q[4] & (rt_q != '0) & id_valid &
         ((rt_q == id_rs) | (id_uses_rt & (rt_q == id_rt)));
    stall      = hz & ~flush;
    pc_write   = ~stall;
    ifid_write = ~stall;
  end

  always_comb begin
    valid_d = id_valid;
    pc_d    = id_pc;
    data1_d = id_data1;
    data2_d = id_data2;
    imm_d   = id_imm;
    rs_d    = id_rs;
    rt_d    = id_rt;
    rd_d    = id_rd;
    ctl_d   = id_valid ? {id_RegWrite, id_MemRead, id_MemWrite,
                          id_MemToReg, id_RegDst, id_ALUSrc} : 6'b0;
    op_d    = id_valid ? id_ALUOp : 3'b0;
    if (flush || stall) begin
      // Zeroed addresses keep the bubble invisible to the forwarding compare
      valid_d = 1'b0;
      pc_d    = '0;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      ctl_d   = 6'b0;
      op_d    = 3'b0;
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      ctl_q       <= 6'b0;
      op_q        <= 3'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      ctl_q       <= ctl_d;
      op_q        <= op_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_data1    = data1_q;
  assign ex_data2    = data2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_RegWrite = ctl_q[5];
  assign ex_MemRead  = ctl_q[4];
  assign ex_MemWrite = ctl_q[3];
  assign ex_MemToReg = ctl_q[2];
  assign ex_RegDst   = ctl_q[1];
  assign ex_ALUSrc   = ctl_q[0];
  assign ex_ALUOp    = op_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. It captures decoded operands, register addresses and control bits from the decode stage and presents them to the execute stage. The forwarding unit compares its source addresses against the downstream write addresses. It also detects a load-use dependency on the instruction currently in EX: when one is found it freezes PC and IF/ID, inserts a bubble, and counts stall and flush events for performance monitoring.

## Interface
- DATA_W, 32, operand/immediate/PC width
- ADDR_W, 5, register address width
- CNT_W, 16, width of the saturating event counters
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  DATA_W  PC+4 of the decode instruction
- id_rs, id_rt, id_rd  in  ADDR_W  decoded register addresses
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, beq/bne)
- id_data1, id_data2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_RegDst, id_ALUSrc  in  1 each  control bits
- id_ALUOp  in  3  ALU operation class
- flush  in  1  branch/jump taken in EX; squash the decode instruction
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_data1, ex_data2, ex_imm  out  DATA_W  registered copies
- ex_rs, ex_rt, ex_rd  out  ADDR_W  registered addresses (rs/rt feed the forwarding compare)
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegDst, ex_ALUSrc  out  1 each
- ex_ALUOp  out  3
- pc_write  out  1  PC register enable (combinational)
- ifid_write  out  1  IF/ID register enable (combinational)
- stall  out  1  load-use stall this cycle (combinational)
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Hazard condition, combinational: hz = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- stall = hz & ~flush. pc_write = ~stall. ifid_write = ~stall.
- Register update each rising edge, in priority order:
  - flush = 1: load a bubble.
  - stall = 1: load a bubble.
  - otherwise: load all id_* fields, with ex_valid = id_valid.
- Bubble: ex_valid and all control outputs are 0, ALUOp is 0, and address fields are 0 so they never match in forwarding. Data/PC/imm fields may hold any value; they are reset/cleared to 0.
- If id_valid = 0 and there is no flush or stall, the fields are loaded but the control bits are forced to 0 (no architectural effect).
- A flush while a load-use hazard exists: flush wins. The bubble is inserted, pc_write = 1 so the redirect takes effect, stall = 0, and stall_count does not increment.
- An address of $0 never creates a hazard, even when the load targets $0.
- Counters:
  - stall_count += 1 on each cycle with stall = 1.
  - flush_count += 1 on each cycle with flush = 1.
  - Both saturate at all-ones and never wrap.
- Reset, asynchronous: every registered output goes to 0, including ex_valid and both counters. Following reset, with no valid instruction present, pc_write = 1, ifid_write = 1 and stall = 0.
- Reset asserted mid-stall: the stall is abandoned. The pipeline resumes from an empty EX slot on the first clock after rst deasserts.

## Timing
- Latency: 1 cycle from id_* to ex_*.
- A load-use stall lasts exactly 1 cycle. The cycle after the stall, EX holds a bubble, so hz = 0 and the held decode instruction advances on the next edge. The loaded value is then in MEM/WB and reaches EX through forwarding.
- Back-to-back loads each with a dependent consumer: one stall per pair, never two consecutive stall cycles for the same consumer.
- pc_write, ifid_write and stall settle in the same cycle as their inputs. Both enables are sampled by the upstream registers at the same edge that loads the bubble.
- Counter increments are visible the cycle after the event.

## Test plan
- Reset with rst pulsed mid-cycle: all ex_* = 0, counters = 0, pc_write = 1 and stall = 0 immediately, without waiting for a clock.
- lw $8 in EX (ex_MemRead = 1, ex_rt = 8), then add $9,$8,$10 in ID: stall = 1 and pc_write = ifid_write = 0 for one cycle. Next edge: ex_valid = 0 and ex_RegWrite = 0. Following edge: ex_rs = 8 and ex_RegWrite = 1. stall_count = 1.
- lw $0 followed by a consumer of $0, and lw $8 followed by an instruction with id_uses_rt = 0 and id_rt = 8: stall stays 0 in both cases, and the instruction passes in 1 cycle.
- Hazard and flush in the same cycle: stall = 0, pc_write = 1, a bubble is loaded, flush_count = 1 and stall_count is unchanged.
- Independent ALU stream for 10 cycles: each ex_* equals the previous cycle's id_* and there are no stalls. With id_valid = 0 on one cycle, that slot shows ex_valid = 0 and ex_RegWrite = 0.
- Force stall every cycle for 2^CNT_W + 5 cycles (CNT_W = 4 build): stall_count saturates at 15 and holds there.
